// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action encoding, mapped keycodes and frame-counter width.
// Used by the keycode mapper, this sequencer and the sprite logic.
package fighter_pkg;

  localparam int FRAME_W = 5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WALK_L  = 4'd1,
    WALK_R  = 4'd2,
    CROUCH  = 4'd3,
    JUMP    = 4'd4,
    PUNCH   = 4'd5,
    KICK    = 4'd6,
    HITSTUN = 4'd7
  } action_t;

  localparam logic [7:0] KEY_JUMP   = 8'h1A;
  localparam logic [7:0] KEY_CROUCH = 8'h16;
  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_PUNCH  = 8'h0E;
  localparam logic [7:0] KEY_KICK   = 8'h13;

  // Timed states run to completion and ignore new key decisions.
  function automatic logic is_timed(input action_t a);
    return a inside {JUMP, PUNCH, KICK, HITSTUN};
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Per-state frame counter: clears or advances on tick, saturates at all-ones,
// and flags the last frame of a state whose duration is 'limit'.
module frame_timer
  import fighter_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               clear,
  input  logic [FRAME_W:0]   limit,
  output logic [FRAME_W-1:0] count,
  output logic               done
);

  localparam logic [FRAME_W-1:0] SAT = '1;

  logic [FRAME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (clear) begin
        count_d = '0;
      end else if (count_q != SAT) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // limit of 0 never matches, which is how free states opt out.
  assign done  = ({1'b0, count_q} == (limit - 1'b1));

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player move sequencer: turns the mapped keycode and hit pulses into an
// action state, animation frame index and attack window, advanced once per video frame.
module player_action_ctrl
  import fighter_pkg::*;
#(
  parameter int JUMP_FRAMES  = 32,
  parameter int PUNCH_FRAMES = 12,
  parameter int KICK_FRAMES  = 16,
  parameter int ACT_START    = 4,
  parameter int ACT_LEN      = 4,
  parameter int STUN_FRAMES  = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [7:0]         keycode,
  input  logic               hit_in,
  output logic [3:0]         action,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               attack_active,
  output logic               busy
);

  if (JUMP_FRAMES < 1 || JUMP_FRAMES > 32 || PUNCH_FRAMES < 1 || PUNCH_FRAMES > 32 ||
      KICK_FRAMES < 1 || KICK_FRAMES > 32 || STUN_FRAMES < 1 || STUN_FRAMES > 32 ||
      ACT_START < 0 || ACT_LEN < 0 || ACT_START + ACT_LEN > 32) begin : g_param_check
    $error("player_action_ctrl: frame parameters must fit the 5-bit timer");
  end

  localparam logic [FRAME_W:0] JUMP_LIM  = (FRAME_W+1)'(JUMP_FRAMES);
  localparam logic [FRAME_W:0] PUNCH_LIM = (FRAME_W+1)'(PUNCH_FRAMES);
  localparam logic [FRAME_W:0] KICK_LIM  = (FRAME_W+1)'(KICK_FRAMES);
  localparam logic [FRAME_W:0] STUN_LIM  = (FRAME_W+1)'(STUN_FRAMES);
  localparam logic [FRAME_W:0] ACT_LO    = (FRAME_W+1)'(ACT_START);
  localparam logic [FRAME_W:0] ACT_HI    = (FRAME_W+1)'(ACT_START + ACT_LEN);

  action_t            state_q, state_d;
  logic [7:0]         prev_key_q, prev_key_d;
  logic               hit_pend_q, hit_pend_d;
  logic               hit_seen;
  logic               timer_clear;
  logic               timer_done;
  logic [FRAME_W:0]   timer_limit;
  logic [FRAME_W-1:0] timer_count;
  action_t            free_next;
  logic               press_edge;

  // Punch and kick fire only on a fresh press; held keys fall through to IDLE.
  always_comb begin
    press_edge = (keycode != prev_key_q);
    free_next  = IDLE;
    if (keycode == KEY_PUNCH && press_edge) begin
      free_next = PUNCH;
    end else if (keycode == KEY_KICK && press_edge) begin
      free_next = KICK;
    end else begin
      case (keycode)
        KEY_JUMP:   free_next = JUMP;
        KEY_CROUCH: free_next = CROUCH;
        KEY_LEFT:   free_next = WALK_L;
        KEY_RIGHT:  free_next = WALK_R;
        default:    free_next = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      JUMP:    timer_limit = JUMP_LIM;
      PUNCH:   timer_limit = PUNCH_LIM;
      KICK:    timer_limit = KICK_LIM;
      HITSTUN: timer_limit = STUN_LIM;
      default: timer_limit = '0;
    endcase
  end

  always_comb begin
    hit_seen    = hit_pend_q | hit_in;
    state_d     = state_q;
    timer_clear = 1'b0;
    if (!enable) begin
      state_d     = IDLE;
      timer_clear = 1'b1;
    end else if (hit_seen) begin
      state_d     = HITSTUN;
      timer_clear = 1'b1;
    end else if (is_timed(state_q)) begin
      if (timer_done) begin
        state_d     = IDLE;
        timer_clear = 1'b1;
      end
    end else begin
      state_d     = free_next;
      timer_clear = (free_next != state_q);
    end
    hit_pend_d = frame_tick ? 1'b0 : hit_seen;
    prev_key_d = frame_tick ? keycode : prev_key_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      prev_key_q <= '0;
      hit_pend_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        state_q <= state_d;
      end
      prev_key_q <= prev_key_d;
      hit_pend_q <= hit_pend_d;
    end
  end

  frame_timer u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (frame_tick),
    .clear (timer_clear),
    .limit (timer_limit),
    .count (timer_count),
    .done  (timer_done)
  );

  assign action        = state_q;
  assign anim_frame    = timer_count;
  assign busy          = is_timed(state_q);
  assign attack_active = (state_q == PUNCH || state_q == KICK) &&
                         ({1'b0, timer_count} >= ACT_LO) &&
                         ({1'b0, timer_count} <  ACT_HI);

endmodule
